// File: rtl/pad_alsaqr_bank_ctrl.sv
// Pad-bank controller: per-pad config registers loaded over valid/ready, break-before-make
// direction turnaround, and a synchronised, optionally debounced input path.
module pad_alsaqr_bank_ctrl #(
  parameter int NUM_PADS    = 32,
  parameter int TURN_CYC    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC     = 8,
  parameter int IDX_W       = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [IDX_W-1:0]      cfg_idx_i,
  input  logic                  cfg_oe_i,
  input  logic [1:0]            cfg_drv_i,
  input  logic                  cfg_puen_i,
  input  logic                  cfg_smt_i,
  output logic                  cfg_err_o,
  input  logic [NUM_PADS-1:0]   out_i,
  output logic [NUM_PADS-1:0]   in_o,
  output logic [NUM_PADS-1:0]   pad_oen_o,
  output logic [NUM_PADS-1:0]   pad_i_o,
  input  logic [NUM_PADS-1:0]   pad_o_i,
  output logic [2*NUM_PADS-1:0] pad_drv_o,
  output logic [NUM_PADS-1:0]   pad_puen_o,
  output logic [NUM_PADS-1:0]   pad_smt_o
);
  localparam int CNT_W = $clog2(TURN_CYC + 1);
  localparam int DEB_W = $clog2(DEB_CYC + 1);

  typedef enum logic {IDLE, TURN} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      tidx_q;
  logic                  toe_q;
  logic                  err_q;
  logic [NUM_PADS-1:0]   oen_q, puen_q, smt_q, pi_q, in_q, in_d;
  logic [2*NUM_PADS-1:0] drv_q;
  logic [NUM_PADS-1:0]   sync_q [SYNC_STAGES];
  logic [DEB_W-1:0]      deb_q  [NUM_PADS];
  logic [DEB_W-1:0]      deb_d  [NUM_PADS];
  logic [NUM_PADS-1:0]   s;

  logic accept, idx_ok, cur_out;

  assign accept = cfg_valid_i & (state_q == IDLE);
  assign idx_ok = (int'(cfg_idx_i) < NUM_PADS);

  always_comb begin
    cur_out = 1'b0;
    for (int p = 0; p < NUM_PADS; p++)
      if (int'(cfg_idx_i) == p) cur_out = ~oen_q[p];
  end

  // Config FSM: OEN is held high for TURN_CYC edges whenever a pad changes direction
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tidx_q  <= '0;
      toe_q   <= 1'b0;
      err_q   <= 1'b0;
      oen_q   <= '1;
      drv_q   <= '0;
      puen_q  <= '0;
      smt_q   <= '0;
    end else begin
      err_q <= accept & ~idx_ok;
      case (state_q)
        IDLE: begin
          if (accept && idx_ok) begin
            for (int p = 0; p < NUM_PADS; p++) begin
              if (int'(cfg_idx_i) == p) begin
                drv_q[2*p +: 2] <= cfg_drv_i;
                puen_q[p]       <= cfg_puen_i;
                smt_q[p]        <= cfg_smt_i;
                oen_q[p]        <= (cfg_oe_i == cur_out) ? ~cfg_oe_i : 1'b1;
              end
            end
            if (cfg_oe_i != cur_out) begin
              state_q <= TURN;
              cnt_q   <= CNT_W'(TURN_CYC);
              tidx_q  <= cfg_idx_i;
              toe_q   <= cfg_oe_i;
            end
          end
        end
        TURN: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            for (int p = 0; p < NUM_PADS; p++)
              if (int'(tidx_q) == p) oen_q[p] <= ~toe_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Input synchroniser
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad_o_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce: a pad in turnaround is frozen with its run counter cleared
  always_comb begin
    in_d = in_q;
    for (int p = 0; p < NUM_PADS; p++) begin
      deb_d[p] = '0;
      if (!(state_q == TURN && int'(tidx_q) == p)) begin
        if (!smt_q[p]) begin
          in_d[p] = s[p];
        end else if (s[p] != in_q[p]) begin
          if (deb_q[p] == DEB_W'(DEB_CYC - 1)) in_d[p] = s[p];
          else deb_d[p] = deb_q[p] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      in_q <= '0;
      pi_q <= '0;
      for (int p = 0; p < NUM_PADS; p++) deb_q[p] <= '0;
    end else begin
      in_q <= in_d;
      pi_q <= out_i;
      for (int p = 0; p < NUM_PADS; p++) deb_q[p] <= deb_d[p];
    end
  end

  assign cfg_ready_o = (state_q == IDLE);
  assign cfg_err_o   = err_q;
  assign in_o        = in_q;
  assign pad_oen_o   = oen_q;
  assign pad_i_o     = pi_q;
  assign pad_drv_o   = drv_q;
  assign pad_puen_o  = puen_q;
  assign pad_smt_o   = smt_q;

endmodule

// File: tb/tb_pad_alsaqr_bank_ctrl.sv
// Bench for pad_alsaqr_bank_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural bank model.
module tb_pad_alsaqr_bank_ctrl;
  localparam int NP = 20, TC = 2, SS = 2, DB = 8, IW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0, cfg_valid = 1'b0, cfg_ready, cfg_err;
  logic [IW-1:0]   cfg_idx = '0;
  logic            cfg_oe = 1'b0, cfg_puen = 1'b0, cfg_smt = 1'b0;
  logic [1:0]      cfg_drv = '0;
  logic [NP-1:0]   out_v = '0, pad_o = '0, in_v, oen, pad_i, puen, smt;
  logic [2*NP-1:0] drv;

  pad_alsaqr_bank_ctrl #(.NUM_PADS(NP), .TURN_CYC(TC), .SYNC_STAGES(SS), .DEB_CYC(DB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_idx_i(cfg_idx), .cfg_oe_i(cfg_oe), .cfg_drv_i(cfg_drv), .cfg_puen_i(cfg_puen),
    .cfg_smt_i(cfg_smt), .cfg_err_o(cfg_err), .out_i(out_v), .in_o(in_v),
    .pad_oen_o(oen), .pad_i_o(pad_i), .pad_o_i(pad_o), .pad_drv_o(drv),
    .pad_puen_o(puen), .pad_smt_o(smt)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the bank
  logic [NP-1:0] m_oen, m_puen, m_smt, m_pi, m_in;
  logic [1:0]    m_drv [NP];
  logic          m_err, m_toe;
  int            m_busy, m_tidx;
  int            m_run [NP];
  logic [NP-1:0] hist [$];
  bit            m_init = 1'b0;

  function automatic logic [2*NP-1:0] m_drv_vec();
    logic [2*NP-1:0] r;
    r = '0;
    for (int p = 0; p < NP; p++) r[2*p +: 2] = m_drv[p];
    return r;
  endfunction

  always @(posedge clk) begin
    logic [NP-1:0] sv;
    int ci;
    if (!rst_n) begin
      m_oen = '1; m_puen = '0; m_smt = '0; m_pi = '0; m_in = '0; m_err = 1'b0;
      m_busy = 0; m_tidx = 0; m_toe = 1'b0;
      for (int p = 0; p < NP; p++) begin m_drv[p] = 2'b00; m_run[p] = 0; end
      hist = {};
      for (int i = 0; i < SS; i++) hist.push_front('0);
      m_init = 1'b1;
    end else begin
      sv = hist[SS-1];
      for (int p = 0; p < NP; p++) begin
        if (m_busy > 0 && m_tidx == p) m_run[p] = 0;
        else if (!m_smt[p]) begin m_in[p] = sv[p]; m_run[p] = 0; end
        else if (sv[p] != m_in[p]) begin
          m_run[p]++;
          if (m_run[p] == DB) begin m_in[p] = sv[p]; m_run[p] = 0; end
        end else m_run[p] = 0;
      end
      hist.push_front(pad_o);
      void'(hist.pop_back());
      m_err = 1'b0;
      if (m_busy > 0) begin
        if (m_busy == 1) m_oen[m_tidx] = ~m_toe;
        m_busy--;
      end else if (cfg_valid) begin
        ci = int'(cfg_idx);
        if (ci >= NP) m_err = 1'b1;
        else begin
          m_drv[ci] = cfg_drv; m_puen[ci] = cfg_puen; m_smt[ci] = cfg_smt;
          if (cfg_oe == ~m_oen[ci]) m_oen[ci] = ~cfg_oe;
          else begin m_oen[ci] = 1'b1; m_busy = TC; m_tidx = ci; m_toe = cfg_oe; end
        end
      end
      m_pi = out_v;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("oen",   64'(oen),       64'(m_oen));
      chk("in",    64'(in_v),      64'(m_in));
      chk("pad_i", 64'(pad_i),     64'(m_pi));
      chk("drv",   64'(drv),       64'(m_drv_vec()));
      chk("puen",  64'(puen),      64'(m_puen));
      chk("smt",   64'(smt),       64'(m_smt));
      chk("ready", 64'(cfg_ready), 64'(m_busy == 0));
      chk("err",   64'(cfg_err),   64'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int idx, input bit oe, input logic [1:0] d, input bit pu, input bit sm);
    int w;
    w = 0;
    while (!cfg_ready && w < 20) begin tick(); w++; end
    chk("ready_wait", 64'(cfg_ready), 64'(1));
    cfg_idx = IW'(idx); cfg_oe = oe; cfg_drv = d; cfg_puen = pu; cfg_smt = sm;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  logic [NP-1:0]   snap_oen, snap_puen, snap_smt;
  logic [2*NP-1:0] snap_drv;
  bit              seen, rdy;
  int              gl_bit, gl_cnt;

  initial begin
    // Reset held three cycles
    repeat (3) tick();
    chk("rst_oen",   64'(oen),       64'(20'hFFFFF));
    chk("rst_in",    64'(in_v),      64'(0));
    chk("rst_ready", 64'(cfg_ready), 64'(1));
    chk("rst_drv",   64'(drv),       64'(0));
    rst_n = 1'b1;
    tick();

    // Same-direction config, back to back
    send(5, 1'b0, 2'b11, 1'b1, 1'b0);
    chk("same_drv5",  64'(drv[11:10]), 64'(3));
    chk("same_puen5", 64'(puen[5]),    64'(1));
    chk("same_ready", 64'(cfg_ready),  64'(1));
    send(6, 1'b0, 2'b01, 1'b0, 1'b0);
    chk("b2b_drv6",   64'(drv[13:12]), 64'(1));

    // Turnaround input -> output on pad 3
    send(3, 1'b1, 2'b10, 1'b0, 1'b0);
    chk("turn_oen_k",    64'(oen[3]),    64'(1));
    chk("turn_ready_k",  64'(cfg_ready), 64'(0));
    tick();
    chk("turn_oen_k1",   64'(oen[3]),    64'(1));
    chk("turn_ready_k1", 64'(cfg_ready), 64'(0));
    tick();
    chk("turn_oen_k2",   64'(oen[3]),    64'(0));
    chk("turn_ready_k2", 64'(cfg_ready), 64'(1));
    // Reverse: output -> input releases OEN immediately
    send(3, 1'b0, 2'b10, 1'b0, 1'b0);
    chk("rev_oen_k",   64'(oen[3]),    64'(1));
    chk("rev_ready_k", 64'(cfg_ready), 64'(0));
    tick(); tick();
    chk("rev_oen_end", 64'(oen[3]),    64'(1));

    // Debounce on pad 0
    send(0, 1'b0, 2'b00, 1'b0, 1'b1);
    repeat (5) tick();
    pad_o[0] = 1'b1;
    repeat (5) tick();
    pad_o[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (in_v[0]) seen = 1'b1; end
    chk("glitch_rejected", 64'(seen), 64'(0));
    pad_o[0] = 1'b1;
    repeat (SS + DB - 1) tick();
    chk("deb_before", 64'(in_v[0]), 64'(0));
    tick();
    chk("deb_after",  64'(in_v[0]), 64'(1));
    repeat (10) tick();
    pad_o[0] = 1'b0;
    repeat (15) tick();

    // Out-of-range index
    snap_oen = oen; snap_drv = drv; snap_puen = puen; snap_smt = smt;
    send(25, 1'b1, 2'b11, 1'b1, 1'b1);
    chk("bad_err",  64'(cfg_err), 64'(1));
    chk("bad_oen",  64'(oen),     64'(snap_oen));
    chk("bad_drv",  64'(drv),     64'(snap_drv));
    chk("bad_puen", 64'(puen),    64'(snap_puen));
    chk("bad_smt",  64'(smt),     64'(snap_smt));
    tick();
    chk("bad_err_clr", 64'(cfg_err), 64'(0));

    // Reset in the middle of a turnaround
    send(7, 1'b1, 2'b10, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("rst_turn_oen7",  64'(oen[7]),    64'(1));
    chk("rst_turn_ready", 64'(cfg_ready), 64'(1));
    rst_n = 1'b1;
    tick();

    // Randomized traffic
    gl_bit = 0; gl_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy = cfg_ready & rst_n;
      if (!cfg_valid && $urandom_range(0, 2) == 0) begin
        cfg_idx  = IW'($urandom_range(0, 31));
        cfg_oe   = 1'($urandom_range(0, 1));
        cfg_drv  = 2'($urandom_range(0, 3));
        cfg_puen = 1'($urandom_range(0, 1));
        cfg_smt  = 1'($urandom_range(0, 1));
        cfg_valid = 1'b1;
      end
      out_v = NP'($urandom);
      if (gl_cnt > 0) begin
        gl_cnt--;
        if (gl_cnt == 0) pad_o[gl_bit] = ~pad_o[gl_bit];
      end else if ($urandom_range(0, 5) == 0) begin
        gl_bit = $urandom_range(0, NP - 1);
        pad_o[gl_bit] = ~pad_o[gl_bit];
        if ($urandom_range(0, 1) == 1) gl_cnt = $urandom_range(1, 12);
      end
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
      if (cfg_valid && rdy) cfg_valid = 1'b0;
    end
    rst_n = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
